// File: rtl/regfile_write_arbiter_pkg.sv
// Shared types and constants for the register-file write arbiter.
// The FIFO entry layout and the 5-to-32 write-index decoder live here.
package regfile_write_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [DATA_W-1:0]     data;
    } md_entry_t;

    function automatic logic [DATA_W-1:0] decode_rd(input logic [REG_ADDR_W-1:0] rd);
        decode_rd = 32'd1 << rd;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// Writeback bus between the ALU / mult-div producers and the register-file write port.
// md handshake: a result transfers on a rising edge where md_valid && md_ready; the ALU side has no ready.
interface regfile_write_arbiter_if;
    import regfile_write_arbiter_pkg::*;

    logic                  alu_valid;
    logic [REG_ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0]     alu_data;
    logic                  md_valid;
    logic [REG_ADDR_W-1:0] md_rd;
    logic [DATA_W-1:0]     md_data;
    logic                  md_ready;
    logic                  ctrl_writeEnable;
    logic [REG_ADDR_W-1:0] ctrl_writeReg;
    logic [DATA_W-1:0]     data_writeReg;
    logic [DATA_W-1:0]     pending;
    logic                  busy;

    modport master (
        output alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        input  md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, busy
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, md_valid, md_rd, md_data,
        output md_ready, ctrl_writeEnable, ctrl_writeReg, data_writeReg, pending, busy
    );

endinterface

// File: rtl/regfile_wb_fifo.sv
// Circular buffer of mult/div writeback entries with per-entry squash-by-rd.
// Popped slots have their valid bit cleared so per-entry valids can feed pending directly.
module regfile_wb_fifo
    import regfile_write_arbiter_pkg::*;
#(
    parameter int DEPTH  = 2,
    parameter int ADDR_W = REG_ADDR_W
) (
    input  logic                         clock,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  md_entry_t                    push_entry_i,
    input  logic                         pop_i,
    input  logic                         squash_i,
    input  logic [ADDR_W-1:0]            squash_rd_i,
    output logic                         full_o,
    output logic                         empty_o,
    output md_entry_t                    head_o,
    output logic [DEPTH-1:0]             entry_valid_o,
    output logic [DEPTH-1:0][ADDR_W-1:0] entry_rd_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    md_entry_t        mem_q [DEPTH];
    md_entry_t        mem_d [DEPTH];
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        next_ptr = (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign head_o  = mem_q[rd_ptr_q];

    // Squash hits stored entries only; the incoming entry arrives with its own valid already resolved.
    always_comb begin
        mem_d    = mem_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        if (squash_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (mem_q[i].rd == squash_rd_i) mem_d[i].valid = 1'b0;
            end
        end
        if (do_pop) begin
            mem_d[rd_ptr_q].valid = 1'b0;
            rd_ptr_d = next_ptr(rd_ptr_q);
        end
        if (do_push) begin
            mem_d[wr_ptr_q] = push_entry_i;
            wr_ptr_d = next_ptr(wr_ptr_q);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            entry_valid_o[i] = mem_q[i].valid;
            entry_rd_o[i]    = mem_q[i].rd;
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Merges ALU and buffered mult/div writebacks into one registered register-file write per cycle.
// ALU always wins; a taken ALU write squashes older buffered writes to the same register.
module regfile_write_arbiter
    import regfile_write_arbiter_pkg::*;
#(
    parameter int MD_DEPTH   = 2,
    parameter int REG_ADDR_W = 5
) (
    input logic                   clock,
    input logic                   ctrl_reset_n,
    regfile_write_arbiter_if.slave bus
);

    logic                                   alu_take, md_push, fifo_pop;
    logic                                   fifo_full, fifo_empty;
    logic                                   ready_en_q;
    md_entry_t                              push_entry, head;
    logic [MD_DEPTH-1:0]                    entry_valid;
    logic [MD_DEPTH-1:0][REG_ADDR_W-1:0]    entry_rd;
    logic                                   we_q, we_d;
    logic [REG_ADDR_W-1:0]                  wreg_q, wreg_d;
    logic [DATA_W-1:0]                      wdata_q, wdata_d;
    logic [DATA_W-1:0]                      pending;

    assign alu_take = bus.alu_valid && (bus.alu_rd != ZERO_REG);
    assign fifo_pop = !fifo_empty && !alu_take;

    // ready_en_q keeps md_ready low until the first edge after reset release.
    assign bus.md_ready = !fifo_full && ready_en_q;
    assign md_push      = bus.md_valid && bus.md_ready && (bus.md_rd != ZERO_REG);

    // A same-edge mult/div result counts as older than the ALU write, so it lands already squashed.
    always_comb begin
        push_entry       = '0;
        push_entry.valid = !(alu_take && (bus.alu_rd == bus.md_rd));
        push_entry.rd    = bus.md_rd;
        push_entry.data  = bus.md_data;
    end

    regfile_wb_fifo #(
        .DEPTH  (MD_DEPTH),
        .ADDR_W (REG_ADDR_W)
    ) u_fifo (
        .clock         (clock),
        .rst_n         (ctrl_reset_n),
        .push_i        (md_push),
        .push_entry_i  (push_entry),
        .pop_i         (fifo_pop),
        .squash_i      (alu_take),
        .squash_rd_i   (bus.alu_rd),
        .full_o        (fifo_full),
        .empty_o       (fifo_empty),
        .head_o        (head),
        .entry_valid_o (entry_valid),
        .entry_rd_o    (entry_rd)
    );

    always_comb begin
        we_d    = 1'b0;
        wreg_d  = wreg_q;
        wdata_d = wdata_q;
        if (alu_take) begin
            we_d    = 1'b1;
            wreg_d  = bus.alu_rd;
            wdata_d = bus.alu_data;
        end else if (!fifo_empty && head.valid) begin
            we_d    = 1'b1;
            wreg_d  = head.rd;
            wdata_d = head.data;
        end
    end

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            we_q       <= 1'b0;
            wreg_q     <= '0;
            wdata_q    <= '0;
            ready_en_q <= 1'b0;
        end else begin
            we_q       <= we_d;
            wreg_q     <= wreg_d;
            wdata_q    <= wdata_d;
            ready_en_q <= 1'b1;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < MD_DEPTH; i++) begin
            if (entry_valid[i]) pending = pending | decode_rd(entry_rd[i]);
        end
    end

    assign bus.pending          = pending;
    assign bus.busy             = !fifo_empty;
    assign bus.ctrl_writeEnable = we_q;
    assign bus.ctrl_writeReg    = wreg_q;
    assign bus.data_writeReg    = wdata_q;

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed vector table, hand-written reset sequence,
// then a randomized phase checked against a queue-based reference model.
module tb_regfile_write_arbiter;
    import regfile_write_arbiter_pkg::*;

    localparam int MD_DEPTH = 2;
    localparam int NVEC     = 19;
    localparam int NRAND    = 300;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_rd;
        logic [31:0] alu_d;
        logic        md_v;
        logic [4:0]  md_rd;
        logic [31:0] md_d;
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] pend;
        logic        rdy;
        logic        busy;
    } vec_t;

    typedef struct packed {
        logic        we;
        logic [4:0]  wreg;
        logic [31:0] wdata;
        logic [31:0] pend;
        logic        rdy;
        logic        busy;
    } exp_t;

    logic clock;
    logic ctrl_reset_n;
    int   n_vec;
    int   n_miscompare;

    vec_t       vecs [NVEC];
    exp_t       exp_q [$];
    md_entry_t  model_q [$];
    logic [4:0]  m_reg;
    logic [31:0] m_data;

    regfile_write_arbiter_if bus ();

    regfile_write_arbiter #(
        .MD_DEPTH   (MD_DEPTH),
        .REG_ADDR_W (5)
    ) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .bus          (bus)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // driver tasks
    task automatic drive(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic mv, input logic [4:0] mr, input logic [31:0] md);
        bus.alu_valid = av;
        bus.alu_rd    = ar;
        bus.alu_data  = ad;
        bus.md_valid  = mv;
        bus.md_rd     = mr;
        bus.md_data   = md;
    endtask

    task automatic drive_idle();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        if (act !== expv) begin
            n_miscompare++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // scoreboard: pop one expected record and compare every output field
    task automatic compare_out(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_miscompare++;
            $display("FAIL %s: scoreboard empty, got we=%b expected a queued record", tag, bus.ctrl_writeEnable);
        end else begin
            e = exp_q.pop_front();
            chk({tag, ".we"},    {31'd0, bus.ctrl_writeEnable}, {31'd0, e.we});
            chk({tag, ".reg"},   {27'd0, bus.ctrl_writeReg},    {27'd0, e.wreg});
            chk({tag, ".data"},  bus.data_writeReg,             e.wdata);
            chk({tag, ".pend"},  bus.pending,                   e.pend);
            chk({tag, ".ready"}, {31'd0, bus.md_ready},         {31'd0, e.rdy});
            chk({tag, ".busy"},  {31'd0, bus.busy},             {31'd0, e.busy});
        end
    endtask

    // reference model step: squash, then pop/present, then push
    task automatic model_step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                              input logic mv, input logic [4:0] mr, input logic [31:0] md);
        logic      take, acc, we;
        md_entry_t h, ne;
        exp_t      e;
        logic [31:0] pend;
        take = av && (ar != 5'd0);
        acc  = mv && (model_q.size() < MD_DEPTH) && (mr != 5'd0);
        we   = 1'b0;
        if (take) begin
            foreach (model_q[i]) if (model_q[i].rd == ar) model_q[i].valid = 1'b0;
            we = 1'b1; m_reg = ar; m_data = ad;
        end else if (model_q.size() > 0) begin
            h = model_q.pop_front();
            if (h.valid) begin
                we = 1'b1; m_reg = h.rd; m_data = h.data;
            end
        end
        if (acc) begin
            ne.valid = !(take && (ar == mr));
            ne.rd    = mr;
            ne.data  = md;
            model_q.push_back(ne);
        end
        pend = '0;
        foreach (model_q[i]) if (model_q[i].valid) pend[model_q[i].rd] = 1'b1;
        e.we = we; e.wreg = m_reg; e.wdata = m_data; e.pend = pend;
        e.rdy = (model_q.size() < MD_DEPTH); e.busy = (model_q.size() > 0);
        exp_q.push_back(e);
    endtask

    initial begin
        exp_t ev;
        n_vec = 0;
        n_miscompare = 0;

        //              alu_v rd    data           md_v rd    data          we  reg   data           pend          rdy  busy
        vecs[0]  = '{1'b1, 5'd7,  32'hDEADBEEF, 1'b0, 5'd0,  32'h0,     1'b1, 5'd7,  32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
        vecs[1]  = '{1'b1, 5'd0,  32'h12345678, 1'b0, 5'd0,  32'h0,     1'b0, 5'd7,  32'hDEADBEEF, 32'h0,        1'b1, 1'b0};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3,  32'h11,    1'b0, 5'd7,  32'hDEADBEEF, 32'h0000_0008, 1'b1, 1'b1};
        vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd4,  32'h22,    1'b1, 5'd3,  32'h11,       32'h0000_0010, 1'b1, 1'b1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd4,  32'h22,       32'h0,        1'b1, 1'b0};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd4,  32'h22,       32'h0,        1'b1, 1'b0};
        vecs[6]  = '{1'b1, 5'd9,  32'hA1,       1'b1, 5'd5,  32'h55,    1'b1, 5'd9,  32'hA1,       32'h0000_0020, 1'b1, 1'b1};
        vecs[7]  = '{1'b1, 5'd9,  32'hA2,       1'b1, 5'd10, 32'hAA10,  1'b1, 5'd9,  32'hA2,       32'h0000_0420, 1'b0, 1'b1};
        vecs[8]  = '{1'b1, 5'd9,  32'hA3,       1'b0, 5'd0,  32'h0,     1'b1, 5'd9,  32'hA3,       32'h0000_0420, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd12, 32'hCC,    1'b1, 5'd5,  32'h55,       32'h0000_0400, 1'b1, 1'b1};
        vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b1, 5'd10, 32'hAA10,     32'h0,        1'b1, 1'b0};
        vecs[11] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd6,  32'hAA,    1'b0, 5'd10, 32'hAA10,     32'h0000_0040, 1'b1, 1'b1};
        vecs[12] = '{1'b1, 5'd6,  32'hBB,       1'b0, 5'd0,  32'h0,     1'b1, 5'd6,  32'hBB,       32'h0,        1'b1, 1'b1};
        vecs[13] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd6,  32'hBB,       32'h0,        1'b1, 1'b0};
        vecs[14] = '{1'b1, 5'd8,  32'h80,       1'b1, 5'd8,  32'h88,    1'b1, 5'd8,  32'h80,       32'h0,        1'b1, 1'b1};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,     1'b0, 5'd8,  32'h80,       32'h0,        1'b1, 1'b0};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 32'hB11,   1'b0, 5'd8,  32'h80,       32'h0000_0800, 1'b1, 1'b1};
        vecs[17] = '{1'b1, 5'd0,  32'hFFFF,     1'b0, 5'd0,  32'h0,     1'b1, 5'd11, 32'hB11,      32'h0,        1'b1, 1'b0};
        vecs[18] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h999,   1'b0, 5'd11, 32'hB11,      32'h0,        1'b1, 1'b0};

        // reset state
        drive_idle();
        ctrl_reset_n = 1'b0;
        #12;
        n_vec++;
        chk("reset.we",    {31'd0, bus.ctrl_writeEnable}, 32'd0);
        chk("reset.reg",   {27'd0, bus.ctrl_writeReg},    32'd0);
        chk("reset.data",  bus.data_writeReg,             32'd0);
        chk("reset.pend",  bus.pending,                   32'd0);
        chk("reset.busy",  {31'd0, bus.busy},             32'd0);
        chk("reset.ready", {31'd0, bus.md_ready},         32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        @(posedge clock);
        @(negedge clock);

        // directed vector table
        for (int i = 0; i < NVEC; i++) begin
            drive(vecs[i].alu_v, vecs[i].alu_rd, vecs[i].alu_d, vecs[i].md_v, vecs[i].md_rd, vecs[i].md_d);
            ev.we = vecs[i].we; ev.wreg = vecs[i].wreg; ev.wdata = vecs[i].wdata;
            ev.pend = vecs[i].pend; ev.rdy = vecs[i].rdy; ev.busy = vecs[i].busy;
            exp_q.push_back(ev);
            n_vec++;
            @(posedge clock);
            @(negedge clock);
            compare_out($sformatf("vec%0d", i));
        end

        // asynchronous reset while full and writing
        drive(1'b1, 5'd2, 32'h2222, 1'b1, 5'd3, 32'h333);
        @(posedge clock);
        @(negedge clock);
        drive(1'b1, 5'd2, 32'h2223, 1'b1, 5'd4, 32'h444);
        @(posedge clock);
        @(negedge clock);
        n_vec++;
        chk("arst.pre_we",    {31'd0, bus.ctrl_writeEnable}, 32'd1);
        chk("arst.pre_ready", {31'd0, bus.md_ready},         32'd0);
        chk("arst.pre_pend",  bus.pending,                   32'h0000_0018);
        drive_idle();
        #2 ctrl_reset_n = 1'b0;
        #1;
        n_vec++;
        chk("arst.we",    {31'd0, bus.ctrl_writeEnable}, 32'd0);
        chk("arst.reg",   {27'd0, bus.ctrl_writeReg},    32'd0);
        chk("arst.data",  bus.data_writeReg,             32'd0);
        chk("arst.pend",  bus.pending,                   32'd0);
        chk("arst.busy",  {31'd0, bus.busy},             32'd0);
        chk("arst.ready", {31'd0, bus.md_ready},         32'd0);
        @(negedge clock);
        ctrl_reset_n = 1'b1;
        #1;
        n_vec++;
        chk("arst.ready_at_release", {31'd0, bus.md_ready}, 32'd0);
        @(posedge clock);
        #1;
        chk("arst.ready_after_edge", {31'd0, bus.md_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            n_vec++;
            chk("arst.no_stale_we", {31'd0, bus.ctrl_writeEnable}, 32'd0);
            chk("arst.busy_clear",  {31'd0, bus.busy},             32'd0);
        end

        // randomized phase against the reference model
        m_reg  = 5'd0;
        m_data = 32'd0;
        for (int i = 0; i < NRAND; i++) begin
            logic        av, mv;
            logic [4:0]  ar, mr;
            logic [31:0] ad, md;
            av = ($urandom_range(0, 2) == 0);
            ar = 5'($urandom_range(0, 7));
            ad = $urandom;
            mv = ($urandom_range(0, 1) == 0);
            mr = 5'($urandom_range(0, 7));
            md = $urandom;
            drive(av, ar, ad, mv, mr, md);
            model_step(av, ar, ad, mv, mr, md);
            n_vec++;
            @(posedge clock);
            @(negedge clock);
            compare_out($sformatf("rand%0d", i));
        end

        if (exp_q.size() != 0) begin
            n_miscompare++;
            $display("FAIL scoreboard_drain: %0d records left, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
        $finish;
    end

endmodule
